// File: rtl/spw_pkg.sv
// SpaceWire character-level constants shared by the link receiver.
// Control codes are written in wire order: {first payload bit, second payload bit}.
package spw_pkg;

  localparam logic [1:0] CTRL_FCT = 2'b00;
  localparam logic [1:0] CTRL_EOP = 2'b01;
  localparam logic [1:0] CTRL_EEP = 2'b10;
  localparam logic [1:0] CTRL_ESC = 2'b11;

  localparam logic [8:0] NCHAR_EOP = 9'h100;
  localparam logic [8:0] NCHAR_EEP = 9'h101;

  localparam int DATA_LEN = 8;
  localparam int CODE_LEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PAR,
    RX_CTL,
    RX_DATA,
    RX_CODE,
    RX_HALT
  } rx_state_e;

endpackage

// File: rtl/port_rx_bit_recover.sv
// Data/strobe bit recovery: synchronizes both lines, flags a bit on every change of D^S,
// and times the gap between bits to report a disconnect.
module port_rx_bit_recover #(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 85
) (
  input  logic rx_clk,
  input  logic rx_rst,
  input  logic data_i,
  input  logic strobe_i,
  output logic bit_stb_o,
  output logic bit_val_o,
  output logic disc_o
);

  localparam int CW = $clog2(DISC_CYCLES + 1);

  logic [SYNC_STAGES-1:0] d_sync_q;
  logic [SYNC_STAGES-1:0] s_sync_q;
  logic                   x;
  logic                   x_prev_q;
  logic                   armed_q;
  logic [CW-1:0]          idle_q;

  // NOTE: the synchronizer and x_prev keep sampling through reset, so a line pair parked
  // mid-character never shows up as a false bit when reset is released.
  always_ff @(posedge rx_clk) begin
    d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], data_i};
    s_sync_q <= {s_sync_q[SYNC_STAGES-2:0], strobe_i};
    x_prev_q <= x;
  end

  assign x         = d_sync_q[SYNC_STAGES-1] ^ s_sync_q[SYNC_STAGES-1];
  assign bit_stb_o = x ^ x_prev_q;
  assign bit_val_o = d_sync_q[SYNC_STAGES-1];

  // idle_q counts cycles since the last bit, so the flag raised here lands on cycle DISC_CYCLES once registered.
  assign disc_o = armed_q && !bit_stb_o && (idle_q == CW'(DISC_CYCLES - 1));

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      armed_q <= 1'b0;
      idle_q  <= '0;
    end else if (bit_stb_o) begin
      armed_q <= 1'b1;
      idle_q  <= CW'(1);
    end else if (armed_q) begin
      idle_q <= idle_q + CW'(1);
      if (disc_o) armed_q <= 1'b0;
    end
  end

endmodule

// File: rtl/port_rx.sv
// SpaceWire receiver: turns recovered bits into N-chars, FCTs, NULLs and time codes,
// checking parity, escape sequences and disconnect; any error halts until reset.
module port_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 85
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  input  logic       data,
  input  logic       strobe,
  output logic [8:0] rx_nchar,
  output logic       rx_nchar_valid,
  output logic [7:0] rx_time,
  output logic       rx_time_valid,
  output logic       rx_got_null,
  output logic       rx_got_fct,
  output logic       rx_active,
  output logic       rx_err_parity,
  output logic       rx_err_esc,
  output logic       rx_err_disc
);
  import spw_pkg::*;

  logic bit_stb, bit_val, disc_stb;

  port_rx_bit_recover #(
    .SYNC_STAGES(SYNC_STAGES),
    .DISC_CYCLES(DISC_CYCLES)
  ) u_bit_recover (
    .rx_clk   (rx_clk),
    .rx_rst   (rx_rst),
    .data_i   (data),
    .strobe_i (strobe),
    .bit_stb_o(bit_stb),
    .bit_val_o(bit_val),
    .disc_o   (disc_stb)
  );

  rx_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sr_q, sr_d;
  logic       ctl0_q, ctl0_d;
  logic       par_q, par_d;
  logic       chk_q, chk_d;
  logic       esc_q, esc_d;
  logic       active_q, active_d;
  logic [8:0] nchar_q, nchar_d;
  logic       nchar_vld_q, nchar_vld_d;
  logic [7:0] time_q, time_d;
  logic       time_vld_q, time_vld_d;
  logic       null_q, null_d, fct_q, fct_d;
  logic       err_par_q, err_par_d, err_esc_q, err_esc_d, err_disc_q, err_disc_d;

  logic [7:0] rx_byte;
  logic [1:0] ctl_code;

  assign rx_byte  = {bit_val, sr_q};
  assign ctl_code = {ctl0_q, bit_val};

  always_comb begin
    // NOTE: every variable gets its default before any branch, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ctl0_d      = ctl0_q;
    par_d       = par_q;
    chk_d       = chk_q;
    esc_d       = esc_q;
    active_d    = active_q;
    nchar_d     = '0;
    nchar_vld_d = 1'b0;
    time_d      = '0;
    time_vld_d  = 1'b0;
    null_d      = 1'b0;
    fct_d       = 1'b0;
    err_par_d   = 1'b0;
    err_esc_d   = 1'b0;
    err_disc_d  = 1'b0;

    if (disc_stb && state_q != RX_HALT) begin
      err_disc_d = 1'b1;
      state_d    = RX_HALT;
    end else if (bit_stb) begin
      unique case (state_q)
        RX_IDLE, RX_PAR: begin
          par_d   = par_q ^ bit_val;
          chk_d   = (state_q == RX_PAR);
          state_d = RX_CTL;
        end
        RX_CTL: begin
          if (chk_q && !(par_q ^ bit_val)) begin
            err_par_d = 1'b1;
            state_d   = RX_HALT;
          end else begin
            par_d   = 1'b0;
            cnt_d   = '0;
            state_d = bit_val ? RX_CODE : RX_DATA;
          end
        end
        RX_DATA: begin
          sr_d  = {bit_val, sr_q[6:1]};
          par_d = par_q ^ bit_val;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(DATA_LEN - 1)) begin
            state_d = RX_PAR;
            if (esc_q) begin
              esc_d = 1'b0;
              if (active_q) begin
                time_vld_d = 1'b1;
                time_d     = rx_byte;
              end
            end else if (active_q) begin
              nchar_vld_d = 1'b1;
              nchar_d     = {1'b0, rx_byte};
            end
          end
        end
        RX_CODE: begin
          ctl0_d = bit_val;
          par_d  = par_q ^ bit_val;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'(CODE_LEN - 1)) begin
            state_d = RX_PAR;
            if (ctl_code == CTRL_FCT) begin
              if (esc_q) begin
                null_d   = 1'b1;
                active_d = 1'b1;
                esc_d    = 1'b0;
              end else if (active_q) begin
                fct_d = 1'b1;
              end
            end else if (esc_q && active_q) begin
              err_esc_d = 1'b1;
              state_d   = RX_HALT;
            end else if (ctl_code == CTRL_ESC) begin
              esc_d = 1'b1;
            end else if (esc_q) begin
              // Before the first NULL a bad escape pair is simply dropped.
              esc_d = 1'b0;
            end else if (active_q) begin
              nchar_vld_d = 1'b1;
              nchar_d     = (ctl_code == CTRL_EOP) ? NCHAR_EOP : NCHAR_EEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ctl0_q      <= 1'b0;
      par_q       <= 1'b0;
      chk_q       <= 1'b0;
      esc_q       <= 1'b0;
      active_q    <= 1'b0;
      nchar_q     <= '0;
      nchar_vld_q <= 1'b0;
      time_q      <= '0;
      time_vld_q  <= 1'b0;
      null_q      <= 1'b0;
      fct_q       <= 1'b0;
      err_par_q   <= 1'b0;
      err_esc_q   <= 1'b0;
      err_disc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ctl0_q      <= ctl0_d;
      par_q       <= par_d;
      chk_q       <= chk_d;
      esc_q       <= esc_d;
      active_q    <= active_d;
      nchar_q     <= nchar_d;
      nchar_vld_q <= nchar_vld_d;
      time_q      <= time_d;
      time_vld_q  <= time_vld_d;
      null_q      <= null_d;
      fct_q       <= fct_d;
      err_par_q   <= err_par_d;
      err_esc_q   <= err_esc_d;
      err_disc_q  <= err_disc_d;
    end
  end

  assign rx_nchar       = nchar_q;
  assign rx_nchar_valid = nchar_vld_q;
  assign rx_time        = time_q;
  assign rx_time_valid  = time_vld_q;
  assign rx_got_null    = null_q;
  assign rx_got_fct     = fct_q;
  assign rx_active      = active_q;
  assign rx_err_parity  = err_par_q;
  assign rx_err_esc     = err_esc_q;
  assign rx_err_disc    = err_disc_q;

endmodule

// File: tb/tb_port_rx.sv
// Scoreboard bench for port_rx: stimulus encodes characters onto D/S and queues the
// expected pulse with its arrival cycle; a monitor pops and compares every pulse seen.
module tb_port_rx;

  localparam int SYNC_STAGES = 2;
  localparam int DISC_CYCLES = 85;
  localparam int LAT         = SYNC_STAGES + 1;

  localparam logic [1:0] C_FCT = 2'b00;
  localparam logic [1:0] C_EOP = 2'b01;
  localparam logic [1:0] C_EEP = 2'b10;
  localparam logic [1:0] C_ESC = 2'b11;

  typedef enum int {K_NONE, K_NCHAR, K_TIME, K_NULL, K_FCT, K_PAR, K_ESC, K_DISC} kind_e;
  typedef struct {
    kind_e      kind;
    logic [8:0] val;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  logic       rx_clk = 1'b0;
  logic       rx_rst = 1'b1;
  logic       data   = 1'b0;
  logic       strobe = 1'b0;
  logic [8:0] rx_nchar;
  logic       rx_nchar_valid;
  logic [7:0] rx_time;
  logic       rx_time_valid;
  logic       rx_got_null, rx_got_fct, rx_active;
  logic       rx_err_parity, rx_err_esc, rx_err_disc;

  int   cyc      = 0;
  int   last_drv = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_par = 1'b0;

  port_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .DISC_CYCLES(DISC_CYCLES)
  ) dut (
    .rx_clk        (rx_clk),
    .rx_rst        (rx_rst),
    .data          (data),
    .strobe        (strobe),
    .rx_nchar      (rx_nchar),
    .rx_nchar_valid(rx_nchar_valid),
    .rx_time       (rx_time),
    .rx_time_valid (rx_time_valid),
    .rx_got_null   (rx_got_null),
    .rx_got_fct    (rx_got_fct),
    .rx_active     (rx_active),
    .rx_err_parity (rx_err_parity),
    .rx_err_esc    (rx_err_esc),
    .rx_err_disc   (rx_err_disc)
  );

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard, including its cycle.
  int         mon_n;
  kind_e      mon_k;
  logic [8:0] mon_v;
  exp_t       mon_e;

  always @(negedge rx_clk) begin
    if (!rx_rst) begin
      mon_n = int'(rx_nchar_valid) + int'(rx_time_valid) + int'(rx_got_null) + int'(rx_got_fct)
            + int'(rx_err_parity) + int'(rx_err_esc) + int'(rx_err_disc);
      mon_k = K_NONE;
      mon_v = '0;
      if (rx_nchar_valid)     begin mon_k = K_NCHAR; mon_v = rx_nchar; end
      else if (rx_time_valid) begin mon_k = K_TIME;  mon_v = {1'b0, rx_time}; end
      else if (rx_got_null)   mon_k = K_NULL;
      else if (rx_got_fct)    mon_k = K_FCT;
      else if (rx_err_parity) mon_k = K_PAR;
      else if (rx_err_esc)    mon_k = K_ESC;
      else if (rx_err_disc)   mon_k = K_DISC;
      if (mon_n > 1) check("single_pulse", mon_n, 1);
      if (mon_k != K_NONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", mon_k, K_NONE);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", mon_k, mon_e.kind);
          check("pulse_value", mon_v, mon_e.val);
          check("pulse_cycle", mon_e.cyc == cyc ? 0 : cyc, 0);
        end
      end
    end
  end

  task automatic push(input kind_e k, input logic [8:0] v, input int at);
    exp_q.push_back('{kind: k, val: v, cyc: at});
  endtask

  // One D/S bit: exactly one line toggles, then hold for two clocks.
  task automatic send_bit(input logic b);
    if (b != data) data = b;
    else strobe = ~strobe;
    last_drv = cyc;
    repeat (2) @(negedge rx_clk);
  endtask

  task automatic send_char(input logic c, input logic [7:0] pl, input int len, input logic flip,
                           input kind_e ctl_ev, input kind_e end_ev, input logic [8:0] end_val);
    logic pp;
    send_bit(1'b1 ^ prev_par ^ c ^ flip);
    send_bit(c);
    if (ctl_ev != K_NONE) push(ctl_ev, 9'h0, last_drv + LAT);
    pp = 1'b0;
    for (int i = 0; i < len; i++) begin
      send_bit(pl[i]);
      pp = pp ^ pl[i];
    end
    prev_par = pp;
    if (end_ev != K_NONE) push(end_ev, end_val, last_drv + LAT);
  endtask

  task automatic send_data(input logic [7:0] b, input kind_e ev, input logic [8:0] v);
    send_char(1'b0, b, 8, 1'b0, K_NONE, ev, v);
  endtask

  task automatic send_ctrl(input logic [1:0] code, input kind_e ev, input logic [8:0] v);
    send_char(1'b1, {6'b0, code[0], code[1]}, 2, 1'b0, K_NONE, ev, v);
  endtask

  task automatic send_null();
    send_ctrl(C_ESC, K_NONE, 9'h0);
    send_ctrl(C_FCT, K_NULL, 9'h0);
  endtask

  task automatic drain(input int max_cyc);
    int i = 0;
    while (exp_q.size() != 0 && i < max_cyc) begin
      @(negedge rx_clk);
      #1;
      i++;
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge rx_clk);
    rx_rst = 1'b1;
    repeat (4) @(negedge rx_clk);
    rx_rst   = 1'b0;
    prev_par = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge rx_clk);
    check("reset_outputs", {rx_nchar, rx_nchar_valid, rx_time, rx_time_valid, rx_got_null,
                            rx_got_fct, rx_err_parity, rx_err_esc, rx_err_disc}, 0);
    check("reset_active", rx_active, 0);
    rx_rst = 1'b0;

    // Before the first NULL, data and FCT are dropped; then NULL activates the link.
    send_data(8'h55, K_NONE, 9'h0);
    send_ctrl(C_FCT, K_NONE, 9'h0);
    send_null();
    drain(20);
    check("active_after_null", rx_active, 1);

    // Active link: N-chars, FCT, time code and a repeated NULL.
    send_data(8'hA5, K_NCHAR, 9'h0A5);
    send_ctrl(C_EOP, K_NCHAR, 9'h100);
    send_ctrl(C_EEP, K_NCHAR, 9'h101);
    send_ctrl(C_FCT, K_FCT, 9'h0);
    send_data(8'h00, K_NCHAR, 9'h000);
    send_data(8'hFF, K_NCHAR, 9'h0FF);
    send_ctrl(C_ESC, K_NONE, 9'h0);
    send_data(8'h3F, K_TIME, 9'h03F);
    send_null();
    drain(20);

    // Flipped parity bit: error on the C bit, then silence while halted.
    do_reset();
    send_null();
    send_char(1'b0, 8'h12, 8, 1'b1, K_PAR, K_NONE, 9'h0);
    send_data(8'h34, K_NONE, 9'h0);
    send_ctrl(C_FCT, K_NONE, 9'h0);
    drain(20);
    check("active_held_parity", rx_active, 1);

    // ESC followed by EOP is an escape error; later chars are ignored.
    do_reset();
    send_null();
    send_ctrl(C_ESC, K_NONE, 9'h0);
    send_ctrl(C_EOP, K_ESC, 9'h0);
    send_ctrl(C_FCT, K_NONE, 9'h0);
    send_data(8'h77, K_NONE, 9'h0);
    drain(20);
    check("active_held_esc", rx_active, 1);

    // Idle line after a NULL: disconnect on cycle DISC_CYCLES after the last bit strobe.
    do_reset();
    send_null();
    push(K_DISC, 9'h0, last_drv + SYNC_STAGES + DISC_CYCLES);
    drain(120);

    // Reset mid-character, then a NULL whose first parity bit is wrong must still be accepted.
    do_reset();
    check("active_cleared", rx_active, 0);
    send_null();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    drain(20);
    do_reset();
    check("active_after_midchar_rst", rx_active, 0);
    send_char(1'b1, 8'h03, 2, 1'b1, K_NONE, K_NONE, 9'h0);
    send_ctrl(C_FCT, K_NULL, 9'h0);
    send_data(8'h5A, K_NCHAR, 9'h05A);
    drain(20);
    check("active_final", rx_active, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
